mlp_eval_sequencer: RTL and testbench

//  Hardware evaluation sequencer for the MLP core. Generalises single-shot start/done/accuracy evaluation:

---
 rtl/mlp_eval_sequencer_if.sv | 39 +++
 rtl/mlp_eval_sequencer.sv | 139 +++++++++++++
 tb/tb_mlp_eval_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_eval_sequencer_if.sv
// Interface between the evaluation sequencer, its controller (start/abort/results)
// and the MLP core (case launch / completion with labels).
interface mlp_eval_sequencer_if #(
    parameter int CASE_W  = 10,
    parameter int LABEL_W = 4,
    parameter int PASS_W  = 8
);
    // Handshake: start is a request sampled only when the sequencer is not busy.
    // case_start is a one-cycle command to the core. case_done is a one-cycle
    // completion that is consumed only while the sequencer is waiting, with the
    // labels valid in that same cycle. No back-pressure on either side.
    logic               start;
    logic               mode;
    logic               abort;
    logic               case_start;
    logic [CASE_W-1:0]  case_idx;
    logic               case_done;
    logic [LABEL_W-1:0] pred_label;
    logic [LABEL_W-1:0] true_label;
    logic               busy;
    logic               done;
    logic [CASE_W-1:0]  accuracy;
    logic [PASS_W-1:0]  pass_count;
    logic               error;
    logic [CASE_W-1:0]  timeout_case;
    logic [2:0]         dbg_state;

    modport slave (
        input  start, mode, abort, case_done, pred_label, true_label,
        output case_start, case_idx, busy, done, accuracy, pass_count,
               error, timeout_case, dbg_state
    );

    modport master (
        output start, mode, abort, case_done, pred_label, true_label,
        input  case_start, case_idx, busy, done, accuracy, pass_count,
               error, timeout_case, dbg_state
    );
endinterface

// File: rtl/mlp_eval_sequencer.sv
// Evaluation sequencer: launches one MLP inference per test case, scores labels,
// accumulates per-pass accuracy, supports continuous passes, abort and a per-case watchdog.
module mlp_eval_sequencer #(
    parameter int N_CASES = 750,
    parameter int CASE_W  = 10,
    parameter int LABEL_W = 4,
    parameter int TIMEOUT = 4095,
    parameter int TMO_W   = 12,
    parameter int PASS_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mlp_eval_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_FINISH = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_mode;
    logic [CASE_W-1:0]   r_case_idx;
    logic [CASE_W-1:0]   r_correct;
    logic [CASE_W-1:0]   r_accuracy;
    logic [PASS_W-1:0]   r_pass_count;
    logic [CASE_W-1:0]   r_timeout_case;
    logic [TMO_W-1:0]    r_wdog;
    logic                r_done_pulse;

    logic                w_start_go;
    logic                w_case_hit;
    logic                w_pass_end;
    logic                w_timeout;
    logic                w_last_case;
    logic [CASE_W-1:0]   w_match;
    logic [TMO_W-1:0]    w_wdog_inc;

    assign w_last_case = (r_case_idx == CASE_W'(N_CASES - 1));
    assign w_match     = {{(CASE_W-1){1'b0}}, (bus.pred_label == bus.true_label)};
    assign w_wdog_inc  = r_wdog + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // abort outranks every other event; a case_done arriving on the final
    // watchdog cycle is still scored rather than timed out.
    always_comb begin
        w_state_next = r_state;
        w_start_go   = 1'b0;
        w_case_hit   = 1'b0;
        w_pass_end   = 1'b0;
        w_timeout    = 1'b0;
        if (bus.abort && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH, S_ERROR: begin
                    if (bus.start) begin
                        w_start_go   = 1'b1;
                        w_state_next = S_LAUNCH;
                    end
                end
                S_LAUNCH: w_state_next = S_WAIT;
                S_WAIT: begin
                    if (bus.case_done) begin
                        w_case_hit   = 1'b1;
                        w_state_next = S_LAUNCH;
                        if (w_last_case) begin
                            w_pass_end = 1'b1;
                            if (!r_mode) w_state_next = S_FINISH;
                        end
                    end else if (w_wdog_inc == TMO_W'(TIMEOUT)) begin
                        w_timeout    = 1'b1;
                        w_state_next = S_ERROR;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode         <= 1'b0;
            r_case_idx     <= '0;
            r_correct      <= '0;
            r_accuracy     <= '0;
            r_pass_count   <= '0;
            r_timeout_case <= '0;
            r_wdog         <= '0;
            r_done_pulse   <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (w_start_go) begin
                r_mode       <= bus.mode;
                r_case_idx   <= '0;
                r_correct    <= '0;
                r_pass_count <= '0;
            end
            if (r_state == S_LAUNCH) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT) begin
                r_wdog <= w_wdog_inc;
            end
            if (w_case_hit) begin
                if (w_pass_end) begin
                    r_accuracy   <= r_correct + w_match;
                    r_pass_count <= r_pass_count + 1'b1;
                    r_correct    <= '0;
                    r_done_pulse <= r_mode;
                    if (r_mode) r_case_idx <= '0;
                end else begin
                    r_correct  <= r_correct + w_match;
                    r_case_idx <= r_case_idx + 1'b1;
                end
            end
            if (w_timeout) r_timeout_case <= r_case_idx;
        end
    end

    assign bus.case_start   = (r_state == S_LAUNCH);
    assign bus.busy         = (r_state == S_LAUNCH) || (r_state == S_WAIT);
    assign bus.done         = (r_state == S_FINISH) || r_done_pulse;
    assign bus.error        = (r_state == S_ERROR);
    assign bus.case_idx     = r_case_idx;
    assign bus.accuracy     = r_accuracy;
    assign bus.pass_count   = r_pass_count;
    assign bus.timeout_case = r_timeout_case;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_mlp_eval_sequencer.sv
// Directed bench for mlp_eval_sequencer: a small instance (4 cases, timeout 8)
// and a default-parameter instance, each with a background MLP-core responder.
`timescale 1ns/1ps
module tb_mlp_eval_sequencer;
  logic clk;
  logic rst;

  mlp_eval_sequencer_if #(.CASE_W(3), .LABEL_W(4), .PASS_W(8)) sif ();
  mlp_eval_sequencer_if #(.CASE_W(10), .LABEL_W(4), .PASS_W(8)) bif ();

  mlp_eval_sequencer #(.N_CASES(4), .CASE_W(3), .LABEL_W(4), .TIMEOUT(8), .TMO_W(4), .PASS_W(8))
    u_small (.clk(clk), .rst(rst), .bus(sif));

  mlp_eval_sequencer u_big (.clk(clk), .rst(rst), .bus(bif));

  int n_pass;
  int n_total;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // responder configuration for the small instance
  int resp_delay[4];
  bit resp_match[8];
  int resp_cnt;
  bit resp_en;
  int spur_n;
  int spur_seen;
  int s_starts;
  int s_dones;
  int b_starts;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // small-core responder: case_done arrives after the case's WAIT delay (>=50 means never)
  initial begin
    int d;
    sif.case_done = 1'b0;
    sif.pred_label = '0;
    sif.true_label = '0;
    spur_seen = 0;
    tick();
    forever begin
      if (resp_en && sif.case_start) begin
        d = resp_delay[sif.case_idx[1:0]];
        tick();
        if (d < 50) begin
          repeat (d) tick();
          sif.case_done = 1'b1;
          sif.true_label = 4'(resp_cnt + 3);
          sif.pred_label = resp_match[resp_cnt % 8] ? sif.true_label : (sif.true_label ^ 4'h5);
          resp_cnt++;
          tick();
          sif.case_done = 1'b0;
        end
      end else if (spur_n != spur_seen) begin
        spur_seen++;
        sif.case_done = 1'b1;
        sif.true_label = 4'h6;
        sif.pred_label = 4'h6;
        tick();
        sif.case_done = 1'b0;
      end else begin
        tick();
      end
    end
  end

  // big-core responder: always answers in the first WAIT cycle with matching labels
  initial begin
    bif.case_done = 1'b0;
    bif.pred_label = '0;
    bif.true_label = '0;
    tick();
    forever begin
      if (bif.case_start) begin
        tick();
        bif.case_done = 1'b1;
        bif.true_label = 4'(bif.case_idx[3:0]);
        bif.pred_label = 4'(bif.case_idx[3:0]);
        tick();
        bif.case_done = 1'b0;
      end else begin
        tick();
      end
    end
  end

  // pulse monitor, sampled mid-cycle
  always begin
    @(posedge clk);
    #2;
    if (sif.case_start) s_starts++;
    if (sif.done) s_dones++;
    if (bif.case_start) b_starts++;
  end

  task automatic wait_small(input int max, output int n);
    n = 0;
    while (!sif.done && !sif.error && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++;
    if ({sif.busy, sif.done, sif.error, sif.case_start, sif.case_idx, sif.accuracy,
         sif.pass_count, sif.timeout_case, sif.dbg_state} !== '0)
      $display("FAIL reset_small got busy=%0b done=%0b err=%0b cs=%0b idx=%0d acc=%0d pc=%0d st=%0d want all 0",
               sif.busy, sif.done, sif.error, sif.case_start, sif.case_idx, sif.accuracy, sif.pass_count, sif.dbg_state);
    else n_pass++;
    n_total++;
    if ({bif.busy, bif.done, bif.error, bif.case_start, bif.case_idx, bif.accuracy,
         bif.pass_count, bif.timeout_case, bif.dbg_state} !== '0)
      $display("FAIL reset_big got busy=%0b done=%0b acc=%0d want all 0", bif.busy, bif.done, bif.accuracy);
    else n_pass++;
  endtask

  task automatic test_single_pass();
    int n;
    resp_delay = '{0, 0, 0, 0};
    resp_match = '{1, 0, 1, 0, 1, 0, 1, 0};
    resp_cnt = 0;
    resp_en = 1'b1;
    s_starts = 0;
    sif.mode = 1'b0;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    n_total++;
    if (sif.case_start !== 1'b1 || sif.case_idx !== 3'd0)
      $display("FAIL single_launch got cs=%0b idx=%0d want cs=1 idx=0", sif.case_start, sif.case_idx);
    else n_pass++;
    wait_small(40, n);
    n = n + 1;
    n_total++;
    if (n !== 9) $display("FAIL single_latency got %0d want 9", n);
    else n_pass++;
    n_total++;
    if (sif.done !== 1'b1 || sif.busy !== 1'b0)
      $display("FAIL single_done got done=%0b busy=%0b want done=1 busy=0", sif.done, sif.busy);
    else n_pass++;
    n_total++;
    if (sif.accuracy !== 3'd2) $display("FAIL single_accuracy got %0d want 2", sif.accuracy);
    else n_pass++;
    n_total++;
    if (sif.pass_count !== 8'd1) $display("FAIL single_pass_count got %0d want 1", sif.pass_count);
    else n_pass++;
    n_total++;
    if (s_starts !== 4) $display("FAIL single_starts got %0d want 4", s_starts);
    else n_pass++;
    // stray case_done in FINISH must not disturb anything
    spur_n++;
    repeat (4) tick();
    n_total++;
    if (sif.done !== 1'b1 || sif.accuracy !== 3'd2 || sif.pass_count !== 8'd1 || sif.dbg_state !== 3'd3)
      $display("FAIL finish_hold got done=%0b acc=%0d pc=%0d st=%0d want done=1 acc=2 pc=1 st=3",
               sif.done, sif.accuracy, sif.pass_count, sif.dbg_state);
    else n_pass++;
  endtask

  task automatic test_wdog_edge();
    int n;
    resp_delay = '{0, 7, 0, 0};
    resp_match = '{1, 1, 1, 1, 1, 1, 1, 1};
    resp_cnt = 0;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    wait_small(60, n);
    n = n + 1;
    n_total++;
    if (n !== 16) $display("FAIL wdog_edge_latency got %0d want 16", n);
    else n_pass++;
    n_total++;
    if (sif.error !== 1'b0 || sif.done !== 1'b1 || sif.accuracy !== 3'd4)
      $display("FAIL wdog_edge_result got err=%0b done=%0b acc=%0d want err=0 done=1 acc=4",
               sif.error, sif.done, sif.accuracy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    resp_delay = '{0, 0, 99, 0};
    resp_cnt = 0;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    wait_small(60, n);
    n = n + 1;
    n_total++;
    if (n !== 14) $display("FAIL timeout_latency got %0d want 14", n);
    else n_pass++;
    n_total++;
    if (sif.error !== 1'b1 || sif.timeout_case !== 3'd2 || sif.busy !== 1'b0 || sif.done !== 1'b0)
      $display("FAIL timeout_flags got err=%0b tcase=%0d busy=%0b done=%0b want err=1 tcase=2 busy=0 done=0",
               sif.error, sif.timeout_case, sif.busy, sif.done);
    else n_pass++;
    n_total++;
    if (sif.accuracy !== 3'd4 || sif.pass_count !== 8'd0)
      $display("FAIL timeout_hold got acc=%0d pc=%0d want acc=4 pc=0", sif.accuracy, sif.pass_count);
    else n_pass++;
    resp_en = 1'b0;
    repeat (3) tick();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    n_total++;
    if (sif.case_start !== 1'b1 || sif.error !== 1'b0 || sif.case_idx !== 3'd0)
      $display("FAIL timeout_recover got cs=%0b err=%0b idx=%0d want cs=1 err=0 idx=0",
               sif.case_start, sif.error, sif.case_idx);
    else n_pass++;
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    n_total++;
    if (sif.dbg_state !== 3'd0) $display("FAIL timeout_abort got st=%0d want 0", sif.dbg_state);
    else n_pass++;
  endtask

  task automatic test_continuous();
    resp_delay = '{0, 0, 0, 0};
    resp_match = '{1, 1, 1, 0, 0, 1, 0, 0};
    resp_cnt = 0;
    resp_en = 1'b1;
    s_dones = 0;
    sif.mode = 1'b1;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (8) tick();
    n_total++;
    if (sif.done !== 1'b1 || sif.accuracy !== 3'd3 || sif.pass_count !== 8'd1)
      $display("FAIL cont_pass1 got done=%0b acc=%0d pc=%0d want done=1 acc=3 pc=1",
               sif.done, sif.accuracy, sif.pass_count);
    else n_pass++;
    n_total++;
    if (sif.case_start !== 1'b1 || sif.case_idx !== 3'd0)
      $display("FAIL cont_restart got cs=%0b idx=%0d want cs=1 idx=0", sif.case_start, sif.case_idx);
    else n_pass++;
    tick();
    n_total++;
    if (sif.done !== 1'b0 || sif.busy !== 1'b1)
      $display("FAIL cont_pulse got done=%0b busy=%0b want done=0 busy=1", sif.done, sif.busy);
    else n_pass++;
    repeat (7) tick();
    n_total++;
    if (sif.done !== 1'b1 || sif.accuracy !== 3'd1 || sif.pass_count !== 8'd2 || sif.case_idx !== 3'd0)
      $display("FAIL cont_pass2 got done=%0b acc=%0d pc=%0d idx=%0d want done=1 acc=1 pc=2 idx=0",
               sif.done, sif.accuracy, sif.pass_count, sif.case_idx);
    else n_pass++;
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    n_total++;
    if (sif.dbg_state !== 3'd0 || sif.busy !== 1'b0 || sif.done !== 1'b0 ||
        sif.accuracy !== 3'd1 || sif.pass_count !== 8'd2)
      $display("FAIL cont_abort got st=%0d busy=%0b done=%0b acc=%0d pc=%0d want st=0 busy=0 done=0 acc=1 pc=2",
               sif.dbg_state, sif.busy, sif.done, sif.accuracy, sif.pass_count);
    else n_pass++;
    n_total++;
    if (s_dones !== 2) $display("FAIL cont_done_pulses got %0d want 2", s_dones);
    else n_pass++;
    resp_en = 1'b0;
    sif.mode = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_abort_rst();
    resp_delay = '{99, 99, 99, 99};
    resp_en = 1'b1;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (3) tick();
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    n_total++;
    if (sif.dbg_state !== 3'd0 || sif.busy !== 1'b0 || sif.case_start !== 1'b0 || sif.done !== 1'b0 ||
        sif.accuracy !== 3'd1 || sif.pass_count !== 8'd0)
      $display("FAIL abort_wait got st=%0d busy=%0b cs=%0b done=%0b acc=%0d pc=%0d want st=0 busy=0 cs=0 done=0 acc=1 pc=0",
               sif.dbg_state, sif.busy, sif.case_start, sif.done, sif.accuracy, sif.pass_count);
    else n_pass++;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (2) tick();
    #3;
    rst = 1'b1;
    #1;
    n_total++;
    if ({sif.busy, sif.done, sif.error, sif.case_start, sif.case_idx, sif.accuracy,
         sif.pass_count, sif.timeout_case, sif.dbg_state} !== '0)
      $display("FAIL async_rst got busy=%0b acc=%0d pc=%0d tcase=%0d st=%0d want all 0",
               sif.busy, sif.accuracy, sif.pass_count, sif.timeout_case, sif.dbg_state);
    else n_pass++;
    tick();
    rst = 1'b0;
    resp_en = 1'b0;
    tick();
    n_total++;
    if (sif.dbg_state !== 3'd0 || sif.accuracy !== 3'd0)
      $display("FAIL rst_release got st=%0d acc=%0d want 0 0", sif.dbg_state, sif.accuracy);
    else n_pass++;
  endtask

  task automatic test_default_params();
    int n;
    b_starts = 0;
    bif.mode = 1'b0;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    n = 1;
    while (!bif.done && n < 2000) begin
      tick();
      n++;
    end
    n_total++;
    if (n !== 1501) $display("FAIL big_latency got %0d want 1501", n);
    else n_pass++;
    n_total++;
    if (bif.accuracy !== 10'd750 || bif.pass_count !== 8'd1)
      $display("FAIL big_accuracy got acc=%0d pc=%0d want acc=750 pc=1", bif.accuracy, bif.pass_count);
    else n_pass++;
    n_total++;
    if (b_starts !== 750) $display("FAIL big_starts got %0d want 750", b_starts);
    else n_pass++;
    repeat (5) tick();
    n_total++;
    if (bif.done !== 1'b1) $display("FAIL big_done_level got %0b want 1", bif.done);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    resp_en = 1'b0;
    resp_cnt = 0;
    spur_n = 0;
    s_starts = 0;
    s_dones = 0;
    b_starts = 0;
    resp_delay = '{0, 0, 0, 0};
    resp_match = '{1, 1, 1, 1, 1, 1, 1, 1};
    sif.start = 1'b0;
    sif.mode = 1'b0;
    sif.abort = 1'b0;
    bif.start = 1'b0;
    bif.mode = 1'b0;
    bif.abort = 1'b0;
    test_reset();
    test_single_pass();
    test_wdog_edge();
    test_timeout();
    test_continuous();
    test_default_params();
    test_abort_rst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
